ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 device-to-host receiver. It is the next generation of the single-frame PS/2 capture path that feeds the scan-code decode and LED/seven-segment logic in top_level.
- Adds synchroniser depth control, a glitch filter on the PS/2 clock, odd-parity and stop-bit checking, and a frame timeout.
- Buffers received scan codes in a first-word-fall-through FIFO with a valid/ready output, so downstream logic can stall without losing keystrokes.

Parameters:
SYNC_STAGES, 2, number of flops synchronising ps2_clk_in and ps2_data_in (minimum 2)
FILTER_CYCLES, 4, consecutive equal samples required before the filtered PS/2 clock changes level
TIMEOUT_CYCLES, 20000, clk_in cycles without a filtered falling edge before a partial frame is abandoned
FIFO_DEPTH, 8, scan-code entries held (power of two, minimum 2)

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  synchronous reset, active-low
ps2_clk_in  input  1  raw PS/2 clock from the device
ps2_data_in  input  1  raw PS/2 data from the device
code_out  output  8  scan code at FIFO head
valid_out  output  1  FIFO non-empty; code_out valid
ready_in  input  1  consumer accepts code_out when valid_out && ready_in
parity_err_out  output  1  one-cycle pulse: frame dropped for bad parity
frame_err_out  output  1  one-cycle pulse: frame dropped for bad stop bit or timeout
overflow_out  output  1  one-cycle pulse: good frame dropped because the FIFO was full
count_out  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_in==0 at a clk_in edge):
  - FSM goes to IDLE; bit counter, shift register, timeout counter and FIFO pointers clear.
  - Synchroniser and filter flops are set to 1, the bus idle level.
  - Outputs: code_out=0, valid_out=0, count_out=0, all error pulses 0.
  - Reset mid-frame discards the partial frame and raises no error pulse.
- Input conditioning:
  - Both inputs pass through SYNC_STAGES flops.
  - Filtered clock changes level only after FILTER_CYCLES consecutive synchronised samples differ from its current level.
  - fall_edge is a one-cycle strobe on a 1->0 transition of the filtered clock.
  - Data is sampled from the synchronised ps2_data on fall_edge.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall_edge with data==0 (start bit), go to DATA and clear the bit counter. Start bit ==1 is ignored and the FSM stays in IDLE.
  - DATA: each fall_edge shifts data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fall_edge, capture the parity bit and go to STOP.
  - STOP: on fall_edge, return to IDLE and apply the checks below in order:
    - stop bit ==0: pulse frame_err_out.
    - otherwise, ones in data plus parity bit is even: pulse parity_err_out.
    - otherwise, FIFO full: pulse overflow_out.
    - otherwise, push the byte.
  - Timeout: in any non-IDLE state, a counter clears on every fall_edge and increments otherwise. When it reaches TIMEOUT_CYCLES, go to IDLE and pulse frame_err_out. The counter is idle in IDLE.
- Latency: the push happens in the cycle after the stop-bit fall_edge. With the FIFO previously empty, valid_out and code_out update the cycle after the push.
- FIFO:
  - First-word-fall-through: code_out always shows the head entry while valid_out==1. code_out holds its last value when the FIFO is empty.
  - Pop when valid_out && ready_in.
  - Push and pop in the same cycle leave count_out unchanged. This is allowed when full, and a push in this case is not an overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - A pop on empty is impossible by construction, since valid_out gates it.
- Error pulses are exactly one cycle wide and mutually exclusive within a frame.

Test Plan:
- Reset, then one frame for 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1 at 100 ns half-periods. Required: valid_out=1, code_out=0x1C, count_out=1, no error pulses. Then ready_in=1 for one cycle gives valid_out=0 and count_out=0.
- Frame 0x1C with parity bit 1 gives a parity_err_out pulse and count_out stays 0. Frame 0x1C with stop bit 0 gives a frame_err_out pulse and the FIFO is unchanged.
- Send 5 data bits, then hold ps2_clk_in high for TIMEOUT_CYCLES+5 cycles. Required: a frame_err_out pulse and FSM in IDLE. A following good frame 0xF0 is received correctly.
- With ready_in=0, send FIFO_DEPTH+1 frames 0x01..0x09. Required: count_out=8 and one overflow_out pulse on the 9th frame. Draining gives 0x01..0x08 in order, and pointers wrap on later frames.
- Inject 2-cycle (20 ns) low glitches on ps2_clk_in during a frame. Required: no extra bits and code_out is correct.
- Drive rst_in=0 for one cycle after 4 data bits. Required: all outputs at reset values and no error pulse. The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised, glitch-filtered frame capture with
// parity/stop/timeout checking, feeding a first-word-fall-through scan-code FIFO.
module ps2_rx_fifo #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              ps2_clk_in,
    input  logic                              ps2_data_in,
    output logic [7:0]                        code_out,
    output logic                              valid_out,
    input  logic                              ready_in,
    output logic                              parity_err_out,
    output logic                              frame_err_out,
    output logic                              overflow_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_out,
    output logic [1:0]                        state_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   sync_clk;
    logic                   sync_data;
    logic                   filt_clk;
    logic                   filt_prev;
    logic [FW-1:0]          filt_cnt;
    logic                   fall_edge;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
        end
    end

    assign sync_clk  = clk_sync[SYNC_STAGES-1];
    assign sync_data = data_sync[SYNC_STAGES-1];

    // Level flips only after FILTER_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (sync_clk != filt_clk) begin
                if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
                    filt_clk <= sync_clk;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall_edge = filt_prev & ~filt_clk;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] to_cnt;
    logic          timed_out;
    logic          bit_clr;
    logic          shift_en;
    logic          parity_cap;
    logic          frame_err_d;
    logic          parity_err_d;
    logic          push_set;
    logic          push_req;

    assign timed_out = (state_q != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_clr      = 1'b0;
        shift_en     = 1'b0;
        parity_cap   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        push_set     = 1'b0;
        if (timed_out) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall_edge && !sync_data) begin
                        state_d = DATA;
                        bit_clr = 1'b1;
                    end
                end
                DATA: begin
                    if (fall_edge) begin
                        shift_en = 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall_edge) begin
                        parity_cap = 1'b1;
                        state_d    = STOP;
                    end
                end
                STOP: begin
                    if (fall_edge) begin
                        state_d = IDLE;
                        if (!sync_data) begin
                            frame_err_d = 1'b1;
                        end else if (~^{shift_q, parity_q}) begin
                            parity_err_d = 1'b1;
                        end else begin
                            push_set = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bit_cnt        <= '0;
            shift_q        <= '0;
            parity_q       <= 1'b0;
            to_cnt         <= '0;
            frame_err_out  <= 1'b0;
            parity_err_out <= 1'b0;
            push_req       <= 1'b0;
        end else begin
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) begin
                shift_q <= {sync_data, shift_q[7:1]};
            end
            if (parity_cap) begin
                parity_q <= sync_data;
            end
            // Counter only runs while a frame is in flight.
            if (state_d == IDLE || fall_edge) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
            frame_err_out  <= frame_err_d;
            parity_err_out <= parity_err_d;
            push_req       <= push_set;
        end
    end

    assign state_out = state_q;

    // ------------------------------------------------------------------
    // FWFT FIFO. Handshake: code_out is valid while valid_out is high and is
    // consumed on any cycle where valid_out && ready_in; valid_out never
    // depends on ready_in.
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [7:0]    last_code;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign valid_out = (count_q != '0);
    assign do_pop    = valid_out && ready_in;
    // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
    assign do_push      = push_req && (!full || do_pop);
    assign overflow_out = push_req && full && !do_pop;

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            last_code <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                last_code <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // When empty, keep showing the most recently consumed code.
    assign code_out  = valid_out ? mem[rd_ptr] : last_code;
    assign count_out = count_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames and checks the FIFO
// output against a queue of expected scan codes.
module tb_ps2_rx_fifo;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 20000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ready    = 1'b0;
    logic [7:0] code;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       ovf;
    logic [3:0] count;
    logic [1:0] state;

    ps2_rx_fifo #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .ps2_clk_in    (ps2_clk),
        .ps2_data_in   (ps2_data),
        .code_out      (code),
        .valid_out     (valid),
        .ready_in      (ready),
        .parity_err_out(perr),
        .frame_err_out (ferr),
        .overflow_out  (ovf),
        .count_out     (count),
        .state_out     (state)
    );

    // clock / reset block: posedges at 5,15,...; stimulus moves on negedges
    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovf_cnt  = 0;

    // Pulse monitors: a pulse wider than one cycle is counted more than once.
    always @(negedge clk) begin
        if (perr) perr_cnt++;
        if (ferr) ferr_cnt++;
        if (ovf)  ovf_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] c, input logic par_flip,
                                               input logic stop_bit);
        return {stop_bit, (~^c) ^ par_flip, c, 1'b0};
    endfunction

    // driver: bit i is presented 50 ns before the clock falls, low phase 100 ns
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            #50;
            ps2_clk = 1'b0;
            #100;
            ps2_clk = 1'b1;
            if (glitch) begin
                #60;
                ps2_clk = 1'b0;
                #20;
                ps2_clk = 1'b1;
                #20;
            end else begin
                #50;
            end
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic par_flip, input logic stop_bit,
                              input bit glitch);
        send_bits(frame_bits(c, par_flip, stop_bit), 11, glitch);
        repeat (12) @(negedge clk);
    endtask

    // scoreboard pop: wait (bounded) for valid, compare head, consume it
    task automatic drain_one(input string tag);
        int waited;
        logic [7:0] e;
        waited = 0;
        while (!valid && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        e = exp_q.pop_front();
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_code"}, code, e);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_count", count, 0);
        chk("rst_code", code, 0);
        chk("rst_state", state, 0);
        chk("rst_pulses", perr_cnt + ferr_cnt + ovf_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single good frame 0x1C
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(8'h1C);
        chk("t1_count", count, 1);
        chk("t1_perr", perr_cnt, 0);
        chk("t1_ferr", ferr_cnt, 0);
        drain_one("t1");
        chk("t1_valid_after", valid, 0);
        chk("t1_count_after", count, 0);

        // bad parity, then bad stop bit
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        chk("t2_perr", perr_cnt, 1);
        chk("t2_count", count, 0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        chk("t2_ferr", ferr_cnt, 1);
        chk("t2_perr_hold", perr_cnt, 1);
        chk("t2_count_stop", count, 0);
        chk("t2_valid_stop", valid, 0);

        // partial frame abandoned by timeout
        send_bits(frame_bits(8'h55, 1'b0, 1'b1), 6, 1'b0);
        chk("t3_state_data", state, 1);
        chk("t3_no_ferr_yet", ferr_cnt, 1);
        repeat (TIMEOUT + 5) @(negedge clk);
        chk("t3_ferr", ferr_cnt, 2);
        chk("t3_state_idle", state, 0);
        chk("t3_count", count, 0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(8'hF0);
        drain_one("t3_f0");

        // overflow with consumer stalled
        begin
            int exp_ovf;
            exp_ovf = 0;
            for (int i = 1; i <= DEPTH + 1; i++) begin
                send_frame(8'(i), 1'b0, 1'b1, 1'b0);
                if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
                else exp_ovf++;
            end
            chk("t4_count_full", count, DEPTH);
            chk("t4_ovf", ovf_cnt, exp_ovf);
            chk("t4_valid", valid, 1);
        end
        for (int i = 0; i < DEPTH; i++) drain_one("t4_drain");
        chk("t4_count_empty", count, 0);
        for (int k = 0; k < 5; k++) begin
            send_frame(8'hA0 + 8'(k), 1'b0, 1'b1, 1'b0);
            exp_q.push_back(8'hA0 + 8'(k));
        end
        chk("t4_count_wrap", count, 5);
        for (int k = 0; k < 5; k++) drain_one("t4_wrap");

        // short clock glitches inside a frame
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(8'h3C);
        chk("t5_count", count, 1);
        chk("t5_perr", perr_cnt, 1);
        chk("t5_ferr", ferr_cnt, 2);
        drain_one("t5");

        // reset in the middle of a frame with a code still buffered
        send_frame(8'h77, 1'b0, 1'b1, 1'b0);
        send_bits(frame_bits(8'h5A, 1'b0, 1'b1), 5, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        chk("t6_valid", valid, 0);
        chk("t6_count", count, 0);
        chk("t6_code", code, 0);
        chk("t6_state", state, 0);
        repeat (50) @(negedge clk);
        chk("t6_perr", perr_cnt, 1);
        chk("t6_ferr", ferr_cnt, 2);
        chk("t6_ovf", ovf_cnt, 1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(8'h5A);
        drain_one("t6_5a");
        chk("t6_code_hold", code, 8'h5A);
        chk("t6_valid_end", valid, 0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
